// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, ALU encodings and ID/EX payload type
// ALU_ADD is zero so an all-zero bubble decodes as a harmless add of x0.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALU_W  = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_code_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2,
    SRCB_ZERO = 2'd3
  } alu_src_b_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    alu_code_e         alu_code;
    logic              alu_src_a;
    alu_src_b_e        alu_src_b;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decoder/WB inputs and EX-side outputs of the ID/EX stage
// master is the surrounding pipeline, slave is id_ex_stage.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  import id_ex_stage_pkg::*;

  logic [DATA_W-1:0] PC_id;
  logic [REG_AW-1:0] rs1Addr_id;
  logic [REG_AW-1:0] rs2Addr_id;
  logic [REG_AW-1:0] rdAddr_id;
  logic [DATA_W-1:0] Imm_id;
  logic [ALU_W-1:0]  ALUCode_id;
  logic              ALUSrcA_id;
  logic [1:0]        ALUSrcB_id;
  logic              RegWrite_id;
  logic              MemRead_id;
  logic              MemWrite_id;
  logic              MemtoReg_id;
  logic              UseRs1_id;
  logic              UseRs2_id;

  logic              RegWrite_wb;
  logic [REG_AW-1:0] rdAddr_wb;
  logic [DATA_W-1:0] RegWriteData_wb;

  logic              Flush_ex;
  logic              Stall;

  logic [DATA_W-1:0] PC_ex;
  logic [DATA_W-1:0] Imm_ex;
  logic [DATA_W-1:0] rs1Data_ex;
  logic [DATA_W-1:0] rs2Data_ex;
  logic [REG_AW-1:0] rs1Addr_ex;
  logic [REG_AW-1:0] rs2Addr_ex;
  logic [REG_AW-1:0] rdAddr_ex;
  logic [ALU_W-1:0]  ALUCode_ex;
  logic              ALUSrcA_ex;
  logic [1:0]        ALUSrcB_ex;
  logic              RegWrite_ex;
  logic              MemRead_ex;
  logic              MemWrite_ex;
  logic              MemtoReg_ex;
  logic [CNT_W-1:0]  BubbleCount;

  modport master (
    output PC_id, rs1Addr_id, rs2Addr_id, rdAddr_id, Imm_id, ALUCode_id,
           ALUSrcA_id, ALUSrcB_id, RegWrite_id, MemRead_id, MemWrite_id,
           MemtoReg_id, UseRs1_id, UseRs2_id,
           RegWrite_wb, rdAddr_wb, RegWriteData_wb, Flush_ex,
    input  Stall, PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex, rs1Addr_ex,
           rs2Addr_ex, rdAddr_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex,
           RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, BubbleCount
  );

  modport slave (
    input  PC_id, rs1Addr_id, rs2Addr_id, rdAddr_id, Imm_id, ALUCode_id,
           ALUSrcA_id, ALUSrcB_id, RegWrite_id, MemRead_id, MemWrite_id,
           MemtoReg_id, UseRs1_id, UseRs2_id,
           RegWrite_wb, rdAddr_wb, RegWriteData_wb, Flush_ex,
    output Stall, PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex, rs1Addr_ex,
           rs2Addr_ex, rdAddr_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex,
           RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, BubbleCount
  );

endinterface

// File: rtl/id_ex_stage_regfile.sv
// rtl/id_ex_stage_regfile.sv - 2R1W register file, x0 hardwired zero, WB bypass
// Bypass lets an instruction in ID see the value WB is writing this same cycle.
module id_ex_stage_regfile
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem [NREG];
  logic          wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wr_live && wr_addr == rs1_addr) ? wr_data : mem[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      rs2_data = (wr_live && wr_addr == rs2_addr) ? wr_data : mem[rs2_addr];
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - register file, load-use hazard detection and ID/EX register
// A flush or a load-use stall loads an all-zero bubble and bumps a saturating counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              hazard;
  logic              stall;
  logic              load_bubble;
  id_ex_t            ex_q;
  id_ex_t            ex_d;
  logic [CNT_W-1:0]  bubble_cnt;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  id_ex_stage_regfile #(
    .DW (DATA_W),
    .AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (bus.rs1Addr_id),
    .rs2_addr (bus.rs2Addr_id),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (bus.RegWrite_wb),
    .wr_addr  (bus.rdAddr_wb),
    .wr_data  (bus.RegWriteData_wb)
  );

  // Only a load whose result is still in EX forces a stall; later stages forward.
  always_comb begin
    hazard = ex_q.mem_read && (ex_q.rd_addr != '0) &&
             ((bus.UseRs1_id && ex_q.rd_addr == bus.rs1Addr_id) ||
              (bus.UseRs2_id && ex_q.rd_addr == bus.rs2Addr_id));
    stall       = hazard && !bus.Flush_ex;
    load_bubble = bus.Flush_ex || stall;
  end

  always_comb begin
    ex_d            = BUBBLE;
    if (!load_bubble) begin
      ex_d.pc         = bus.PC_id;
      ex_d.imm        = bus.Imm_id;
      ex_d.rs1_data   = rs1_data;
      ex_d.rs2_data   = rs2_data;
      ex_d.rs1_addr   = bus.rs1Addr_id;
      ex_d.rs2_addr   = bus.rs2Addr_id;
      ex_d.rd_addr    = bus.rdAddr_id;
      ex_d.alu_code   = alu_code_e'(bus.ALUCode_id);
      ex_d.alu_src_a  = bus.ALUSrcA_id;
      ex_d.alu_src_b  = alu_src_b_e'(bus.ALUSrcB_id);
      ex_d.reg_write  = bus.RegWrite_id;
      ex_d.mem_read   = bus.MemRead_id;
      ex_d.mem_write  = bus.MemWrite_id;
      ex_d.mem_to_reg = bus.MemtoReg_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (load_bubble && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  assign bus.Stall       = stall;
  assign bus.PC_ex       = ex_q.pc;
  assign bus.Imm_ex      = ex_q.imm;
  assign bus.rs1Data_ex  = ex_q.rs1_data;
  assign bus.rs2Data_ex  = ex_q.rs2_data;
  assign bus.rs1Addr_ex  = ex_q.rs1_addr;
  assign bus.rs2Addr_ex  = ex_q.rs2_addr;
  assign bus.rdAddr_ex   = ex_q.rd_addr;
  assign bus.ALUCode_ex  = ex_q.alu_code;
  assign bus.ALUSrcA_ex  = ex_q.alu_src_a;
  assign bus.ALUSrcB_ex  = ex_q.alu_src_b;
  assign bus.RegWrite_ex = ex_q.reg_write;
  assign bus.MemRead_ex  = ex_q.mem_read;
  assign bus.MemWrite_ex = ex_q.mem_write;
  assign bus.MemtoReg_ex = ex_q.mem_to_reg;
  assign bus.BubbleCount = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] alu, input logic rw, input logic mr,
                        input logic m2r, input logic u1, input logic u2);
    bus.PC_id       = pc;
    bus.Imm_id      = imm;
    bus.rs1Addr_id  = rs1;
    bus.rs2Addr_id  = rs2;
    bus.rdAddr_id   = rd;
    bus.ALUCode_id  = alu;
    bus.ALUSrcA_id  = 1'b1;
    bus.ALUSrcB_id  = 2'd1;
    bus.RegWrite_id = rw;
    bus.MemRead_id  = mr;
    bus.MemWrite_id = 1'b0;
    bus.MemtoReg_id = m2r;
    bus.UseRs1_id   = u1;
    bus.UseRs2_id   = u2;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.RegWrite_wb     = we;
    bus.rdAddr_wb       = a;
    bus.RegWriteData_wb = d;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_id(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    bus.Flush_ex = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Write x3 while reading it in the same cycle: bypass
    set_wb(1'b1, 5'd3, 32'hDEADBEEF);
    set_id(32'h100, 32'h10, 5'd3, 5'd0, 5'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("bypass_rs1", bus.rs1Data_ex, 32'hDEADBEEF);
    check("pc_ex", bus.PC_ex, 32'h100);
    check("rd_ex", {27'd0, bus.rdAddr_ex}, 32'd7);
    check("alu_ex", {28'd0, bus.ALUCode_ex}, 32'd2);
    check("imm_ex", bus.Imm_ex, 32'h10);

    // Write x0 while reading x0: must stay zero
    set_wb(1'b1, 5'd0, 32'h1234);
    set_id(32'h104, 32'h0, 5'd0, 5'd0, 5'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("x0_bypass_rs1", bus.rs1Data_ex, 32'h0);
    check("x0_bypass_rs2", bus.rs2Data_ex, 32'h0);

    // Stored value of x3, x0 still zero, write x5 for the reset check
    set_wb(1'b1, 5'd5, 32'h55);
    set_id(32'h108, 32'h0, 5'd0, 5'd3, 5'd9, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("x0_stored", bus.rs1Data_ex, 32'h0);
    check("x3_stored", bus.rs2Data_ex, 32'hDEADBEEF);

    // One flush so the counter is nonzero before reset
    set_wb(1'b0, 5'd0, 32'h0);
    bus.Flush_ex = 1'b1;
    step();
    bus.Flush_ex = 1'b0;
    check("flush_cnt1", {28'd0, bus.BubbleCount}, 32'd1);
    check("flush_pc_zero", bus.PC_ex, 32'h0);

    // Mid-run reset
    set_id(32'h10C, 32'h4, 5'd5, 5'd3, 5'd4, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    reset = 1'b1;
    #1;
    check("rst_pc", bus.PC_ex, 32'h0);
    check("rst_rs1d", bus.rs1Data_ex, 32'h0);
    check("rst_rd", {27'd0, bus.rdAddr_ex}, 32'd0);
    check("rst_regwrite", {31'd0, bus.RegWrite_ex}, 32'd0);
    check("rst_cnt", {28'd0, bus.BubbleCount}, 32'd0);
    step();
    reset = 1'b0;
    set_id(32'h200, 32'h0, 5'd5, 5'd3, 5'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("rst_x5_cleared", bus.rs1Data_ex, 32'h0);
    check("rst_x3_cleared", bus.rs2Data_ex, 32'h0);

    // Load-use: lw x5 then add reading rs2=x5
    set_wb(1'b1, 5'd5, 32'h0000_5555);
    set_id(32'h300, 32'h8, 5'd3, 5'd0, 5'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    check("lw_memread_ex", {31'd0, bus.MemRead_ex}, 32'd1);
    set_id(32'h304, 32'h0, 5'd3, 5'd5, 5'd6, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("lu_stall", {31'd0, bus.Stall}, 32'd1);
    step();
    check("lu_bubble_rd", {27'd0, bus.rdAddr_ex}, 32'd0);
    check("lu_bubble_memread", {31'd0, bus.MemRead_ex}, 32'd0);
    check("lu_cnt", {28'd0, bus.BubbleCount}, 32'd1);
    check("lu_stall_released", {31'd0, bus.Stall}, 32'd0);
    step();
    check("lu_add_rd", {27'd0, bus.rdAddr_ex}, 32'd6);
    check("lu_add_pc", bus.PC_ex, 32'h304);
    check("lu_add_rs2d", bus.rs2Data_ex, 32'h0000_5555);
    check("lu_add_alu", {28'd0, bus.ALUCode_ex}, 32'd1);

    // No false stall: load to x0, ID reads x0
    set_id(32'h400, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(32'h404, 32'h0, 5'd0, 5'd0, 5'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("nfs_x0_stall", {31'd0, bus.Stall}, 32'd0);
    // Load to x5, ID has rs2=5 but does not use it
    set_id(32'h408, 32'h0, 5'd0, 5'd0, 5'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(32'h40C, 32'h0, 5'd1, 5'd5, 5'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("nfs_unused_stall", {31'd0, bus.Stall}, 32'd0);
    step();
    check("nfs_rd", {27'd0, bus.rdAddr_ex}, 32'd9);
    check("nfs_cnt", {28'd0, bus.BubbleCount}, 32'd1);

    // Flush beats a live hazard
    set_id(32'h500, 32'h0, 5'd0, 5'd0, 5'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(32'h504, 32'h0, 5'd5, 5'd0, 5'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.Flush_ex = 1'b1;
    #1;
    check("flush_no_stall", {31'd0, bus.Stall}, 32'd0);
    step();
    check("flush_bubble_pc", bus.PC_ex, 32'h0);
    check("flush_cnt2", {28'd0, bus.BubbleCount}, 32'd2);

    // Saturation: 20 more flushes from 2 caps at 15
    for (int i = 0; i < 20; i++) begin
      step();
    end
    bus.Flush_ex = 1'b0;
    check("sat_cnt", {28'd0, bus.BubbleCount}, 32'd15);

    // Reset in the middle of a stall
    set_id(32'h600, 32'h0, 5'd0, 5'd0, 5'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(32'h604, 32'h0, 5'd5, 5'd0, 5'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("rs_stall_before", {31'd0, bus.Stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("rs_stall_after", {31'd0, bus.Stall}, 32'd0);
    check("rs_memread", {31'd0, bus.MemRead_ex}, 32'd0);
    check("rs_cnt", {28'd0, bus.BubbleCount}, 32'd0);
    step();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-side neighbour of the EX stage: holds the 32x32 register file, detects load-use hazards and owns the ID/EX pipeline register. It takes decoded fields from the instruction decoder plus the WB write port. It drives every *_ex operand and control signal the EX stage consumes, and also tells IF/PC logic to stall.

Parameters:
DATA_W, 32, register and operand width
REG_AW, 5, register address width (2**REG_AW registers, x0 hardwired zero)
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
PC_id  in  32  PC of instruction in ID
rs1Addr_id, rs2Addr_id, rdAddr_id  in  5 each  register addresses
Imm_id  in  32  sign-extended immediate
ALUCode_id  in  4  ALU op
ALUSrcA_id  in  1  A-operand select
ALUSrcB_id  in  2  B-operand select
RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id  in  1 each  control bits
UseRs1_id, UseRs2_id  in  1 each  instruction actually reads rs1/rs2
RegWrite_wb  in  1  WB write enable
rdAddr_wb  in  5  WB destination
RegWriteData_wb  in  32  WB data
Flush_ex  in  1  branch/jump taken in EX; kill instruction in ID
Stall  out  1  hold PC and IF/ID (combinational)
PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex  out  32 each  registered operands
rs1Addr_ex, rs2Addr_ex, rdAddr_ex  out  5 each  registered addresses
ALUCode_ex  out  4
ALUSrcA_ex  out  1
ALUSrcB_ex  out  2
RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex  out  1 each
BubbleCount  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset (async, active-high):
  - All register-file entries are 0.
  - Every *_ex output is 0, so a bubble is present.
  - BubbleCount is 0.
- Register file:
  - Writes on the rising edge when RegWrite_wb=1 and rdAddr_wb!=0.
  - Writes to x0 are ignored; reads of x0 always return 0.
- Read port:
  - Combinational.
  - Internal WB bypass: if RegWrite_wb=1, rdAddr_wb!=0 and rdAddr_wb equals the read address, RegWriteData_wb is returned in the same cycle.
- Hazard detection, combinational:
  - hazard = MemRead_ex & (rdAddr_ex!=0) & ((UseRs1_id & rdAddr_ex==rs1Addr_id) | (UseRs2_id & rdAddr_ex==rs2Addr_id)).
  - Stall = hazard & ~Flush_ex. Flush wins because the ID instruction is discarded anyway.
- ID/EX register, one action per edge in priority order:
  1. Flush_ex=1 or Stall=1: load a bubble. All control bits, ALUCode, ALUSrc*, addresses, Imm, PC and data are 0.
  2. Otherwise: load all *_id fields and the read-port data.
- Latency: exactly 1 cycle from ID fields to *_ex outputs. A stall inserts exactly one bubble per hazard cycle.
- On the cycle after a load-use stall, the load has moved to MEM. Stall is then 0; EX forwarding covers the dependency.
- BubbleCount:
  - Increments by 1 on each edge where a bubble is loaded due to Stall or Flush_ex.
  - Saturates at 2**CNT_W-1 and does not wrap.
- Reset asserted mid-stall: outputs go to the reset values immediately. Stall is then 0 next cycle because MemRead_ex=0.

Decomposition:
- Shared package holds:
  - ALUCode encodings, with ALU_ADD=4'd0 so the bubble is benign.
  - ALUSrcB encodings.
  - Widths DATA_W and REG_AW.
- One sub-module, regfile, holds the 32x32 array with 2 read ports, 1 write port, x0 rule and WB bypass.
- Hazard logic and the ID/EX register stay in id_ex_stage.

Test Plan:
- Reset check: assert reset mid-run → all *_ex outputs, BubbleCount and every register read are 0. Deassert, then read x5 with UseRs1_id=1 → rs1Data_ex=0 next cycle.
- Write/bypass: WB writes x3=0xDEADBEEF while ID reads rs1=x3 in the same cycle → rs1Data_ex=0xDEADBEEF after 1 edge. Write x0=0x1234 → reads of x0 return 0.
- Load-use: lw x5 in EX (MemRead_ex=1, rdAddr_ex=5), ID add reads rs2=x5 with UseRs2_id=1 → Stall=1 for 1 cycle. Bubble enters EX; BubbleCount=1; next cycle the add enters EX with correct fields.
- No false stall: MemRead_ex=1, rdAddr_ex=0 with rs1=0, or rdAddr_ex=5 with UseRs2_id=0 and rs2=5 → Stall=0, no bubble.
- Flush priority: hazard present and Flush_ex=1 → Stall=0, bubble loaded, BubbleCount increments by 1.
- Saturation: with CNT_W=4, force 20 consecutive flushes → BubbleCount holds at 15.
